// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default sizes for the data-memory controller
package dmem_pkg;
    localparam int DMEM_AW_DEF = 14;
    localparam int WBUF_DEPTH_DEF = 4;
    typedef struct packed {
        logic [DMEM_AW_DEF-1:0] word;
        logic [31:0]            data;
        logic [3:0]             strb;
    } wbuf_entry_t;
endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: posted-write FIFO with head output and parallel word lookup
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   push,
    input  logic                   pop,
    input  wbuf_entry_t            din,
    input  logic [DMEM_AW_DEF-1:0] lk_word,
    output wbuf_entry_t            head,
    output logic                   hit,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    wbuf_entry_t      mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]      cnt_q, cnt_d;
    always_comb begin
        vld_d = vld_q;
        if (push) vld_d[wp_q] = 1'b1;
        if (pop) vld_d[rp_q] = 1'b0;
        wp_d = push ? wp_q + 1'b1 : wp_q;
        rp_d = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) hit = hit | (vld_q[i] && mem_q[i].word == lk_word);
    end
    assign head  = mem_q[rp_q];
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    always_ff @(posedge clk) begin
        if (!resetb) begin
            vld_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) if (push) mem_q[wp_q] <= din;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: core dmem ports to single-port SRAM with posted write buffer; optional DMEM_RANGE_CHK_EN
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          AW         = DMEM_AW_DEF,
    parameter int          WBUF_DEPTH = WBUF_DEPTH_DEF,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          dmem_wready,
    output logic          dmem_wvalid,
    input  logic [31:0]   dmem_waddr,
    input  logic [31:0]   dmem_wdata,
    input  logic [3:0]    dmem_wstrb,
    input  logic          dmem_rready,
    output logic          dmem_rvalid,
    input  logic [31:0]   dmem_raddr,
    output logic          dmem_rresp,
    output logic [31:0]   dmem_rdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic [3:0]    sram_wstrb,
    input  logic [31:0]   sram_rdata,
    output logic          wbuf_empty
);
    logic [AW-1:0] w_word, r_word;
    logic          w_ok, r_ok, push, pop, hit, wb_hit, full, rd_sram, rresp_d, rresp_q;
    wbuf_entry_t   ent, head;
    always_comb begin
        w_word = AW'((dmem_waddr - DMEM_BASE) >> 2);
        r_word = AW'((dmem_raddr - DMEM_BASE) >> 2);
`ifdef DMEM_RANGE_CHK_EN
        w_ok = ((dmem_waddr - DMEM_BASE) >> (AW + 2)) == 32'd0;
        r_ok = ((dmem_raddr - DMEM_BASE) >> (AW + 2)) == 32'd0;
`else
        w_ok = 1'b1;
        r_ok = 1'b1;
`endif
        ent = '{word: DMEM_AW_DEF'(w_word), data: dmem_wdata, strb: dmem_wstrb};
        dmem_wvalid = resetb && dmem_wready && !full;
        push = dmem_wvalid && w_ok;
        // the entry being pushed this cycle is not yet visible to the buffer lookup
        hit = r_ok && (wb_hit || (push && w_word == r_word));
        dmem_rvalid = resetb && dmem_rready && !hit && !full;
        rd_sram = dmem_rvalid && r_ok;
        pop = resetb && !wbuf_empty && !dmem_rvalid;
        sram_cs = rd_sram || pop;
        sram_we = pop;
        sram_addr = rd_sram ? r_word : pop ? AW'(head.word) : '0;
        sram_wdata = pop ? head.data : '0;
        sram_wstrb = pop ? head.strb : '0;
        rresp_d = rd_sram;
        dmem_rresp = rresp_q;
        dmem_rdata = rresp_q ? sram_rdata : '0;
    end
    dmem_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk    (clk),
        .resetb (resetb),
        .push   (push),
        .pop    (pop),
        .din    (ent),
        .lk_word(DMEM_AW_DEF'(r_word)),
        .head   (head),
        .hit    (wb_hit),
        .full   (full),
        .empty  (wbuf_empty)
    );
    always_ff @(posedge clk) rresp_q <= resetb ? rresp_d : 1'b0;
endmodule
